// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg -- N-to-1 channel multiplexer with a one-word registered output.
//
// One input channel is granted per cycle. The granted channel sees in_ready
// whenever the output register can accept a word, i.e. when it is empty or
// being drained this same cycle. A transfer happens when the granted channel
// also has in_valid high; the word appears on y one edge later, tagged with
// its channel index on y_ch.
//
// Optional feature macro: MUX_RR_EN
//   defined   : mode = 1 selects round-robin arbitration starting at a
//               rotating pointer; mode = 0 uses sel.
//   undefined : mode is ignored, sel always picks the channel, no pointer.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_data  in   CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid in   CHANNELS, per-channel valid
//   in_ready out  CHANNELS, one-hot (granted channel) or zero
//   sel      in   SELW, channel index in fixed-select mode
//   mode     in   0 = fixed select, 1 = round-robin (MUX_RR_EN only)
//   y        out  WIDTH, registered selected data
//   y_valid  out  y holds an unconsumed word
//   y_ch     out  SELW, channel index that produced y
//   y_ready  in   downstream accept
module mux_nx1_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SELW-1:0]           y_ch,
  input  logic                      y_ready
);

  logic             load_en;
  logic             fx_vld;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  logic [WIDTH-1:0] y_p0;
  logic [SELW-1:0]  y_ch_p0;
  logic             vld_p0;

  // The output register may take a new word when empty or drained this cycle.
  assign load_en = !vld_p0 || y_ready;

  // Out-of-range select indices grant nothing.
  assign fx_vld = ({1'b0, sel} < (SELW+1)'(CHANNELS));

`ifdef MUX_RR_EN
  logic [SELW-1:0]       ptr_p0;
  logic [2*CHANNELS-1:0] rr_rot;
  logic [SELW:0]         rr_sum;
  logic                  rr_vld;
  logic [SELW-1:0]       rr_gnt;

  // Rotate the valid vector so bit 0 is the pointer position; the lowest set
  // bit is then the first requester at or after the pointer. Scanning from
  // the top down lets the lowest offset overwrite any later one.
  always_comb begin
    rr_rot = {in_valid, in_valid} >> ptr_p0;
    rr_vld = 1'b0;
    rr_gnt = '0;
    rr_sum = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rr_rot[i]) begin
        rr_vld = 1'b1;
        rr_sum = {1'b0, ptr_p0} + (SELW+1)'(i);
        if (rr_sum >= (SELW+1)'(CHANNELS)) begin
          rr_sum = rr_sum - (SELW+1)'(CHANNELS);
        end
        rr_gnt = rr_sum[SELW-1:0];
      end
    end
  end

  always_comb begin
    if (mode) begin
      gnt_vld = rr_vld;
      gnt     = rr_gnt;
    end else begin
      gnt_vld = fx_vld;
      gnt     = sel;
    end
  end

  // Pointer advances past whichever channel just transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_p0 <= '0;
    end else if (xfer) begin
      if ({1'b0, gnt} + 1'b1 >= (SELW+1)'(CHANNELS)) begin
        ptr_p0 <= '0;
      end else begin
        ptr_p0 <= gnt + 1'b1;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    gnt_vld = fx_vld;
    gnt     = sel;
  end
`endif

  // Data path select; in_ready never looks at in_data.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt == SELW'(k)) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rst_n && gnt_vld && load_en && (gnt == SELW'(k))) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Stage p0: output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0    <= '0;
      y_ch_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (xfer) begin
      y_p0    <= gnt_data;
      y_ch_p0 <= gnt;
      vld_p0  <= 1'b1;
    end else if (y_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign y       = y_p0;
  assign y_ch    = y_ch_p0;
  assign y_valid = vld_p0;

endmodule

// File: tb/tb_mux_nx1_reg.sv
module tb_mux_nx1_reg;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [W-1:0]    y;
  logic            y_valid;
  logic [SW-1:0]   y_ch;
  logic            y_ready;

  logic [3*W-1:0]  in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic [1:0]      sel3;
  logic            mode3;
  logic [W-1:0]    y3;
  logic            y_valid3;
  logic [1:0]      y_ch3;
  logic            y_ready3;

  mux_nx1_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .y(y), .y_valid(y_valid),
    .y_ch(y_ch), .y_ready(y_ready)
  );

  mux_nx1_reg #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .y(y3), .y_valid(y_valid3),
    .y_ch(y_ch3), .y_ready(y_ready3)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } item_t;
  item_t sb[$];

  logic          m_valid;
  logic [W-1:0]  m_y;
  logic [SW-1:0] m_ch;
  int            m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = '0;
    m_ch    = '0;
    m_ptr   = 0;
    sb.delete();
  endtask

  // One clock: predict grant, check in_ready, push expected word, advance,
  // pop and compare the registered output.
  task automatic cycle(input string tag);
    logic          le, gv, xf, rr;
    int            g;
    logic [CH-1:0] er;
    item_t         it;
    #1;
    le = !m_valid || y_ready;
    gv = 1'b0;
    g  = 0;
`ifdef MUX_RR_EN
    rr = mode;
`else
    rr = 1'b0;
`endif
    if (rr) begin
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_ptr + i) % CH;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end else if (int'(sel) < CH) begin
      gv = 1'b1;
      g  = int'(sel);
    end
    er = (le && gv) ? (CH'(1) << g) : '0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
    xf = le && gv && in_valid[g];
    if (xf) begin
      it.d  = in_data[g*W +: W];
      it.ch = SW'(g);
      sb.push_back(it);
    end
    @(posedge clk);
    #1;
    if (xf) begin
      it      = sb.pop_front();
      m_valid = 1'b1;
      m_y     = it.d;
      m_ch    = it.ch;
      m_ptr   = (g + 1) % CH;
    end else if (y_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, ".y_valid"}, 64'(y_valid), 64'(m_valid));
    chk({tag, ".y"},       64'(y),       64'(m_y));
    chk({tag, ".y_ch"},    64'(y_ch),    64'(m_ch));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_data   = 32'h44332211;
    in_valid  = 4'hF;
    sel       = 2'd0;
    mode      = 1'b0;
    y_ready   = 1'b1;
    in_data3  = 24'hC3B2A1;
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    mode3     = 1'b0;
    y_ready3  = 1'b1;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    chk("rst.y",         64'(y),         64'h0);
    chk("rst.y_ch",      64'(y_ch),      64'h0);
    chk("rst.y_valid",   64'(y_valid),   64'h0);
    chk("rst.in_ready",  64'(in_ready),  64'h0);
    chk("rst.in_ready3", 64'(in_ready3), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed select sweep, one word per cycle.
    for (int s = 0; s < CH; s++) begin
      sel = SW'(s);
      cycle("fixed");
    end

    // Backpressure: load ch2, hold three cycles (sel moved mid-hold), then
    // drain and load a fresh ch2 word on the same edge.
    sel = 2'd2;
    cycle("bp_load");
    y_ready = 1'b0;
    cycle("bp_hold0");
    sel = 2'd1;
    cycle("bp_hold1");
    sel = 2'd2;
    cycle("bp_hold2");
    in_data = 32'h44A52211;
    y_ready = 1'b1;
    cycle("bp_release");

    // mode = 1 with sel = 1: fixed behaviour unless round-robin is built in.
    in_data = 32'h44332211;
    mode = 1'b1;
    sel  = 2'd1;
    for (int i = 0; i < 3; i++) cycle("mode1");

`ifdef MUX_RR_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    in_valid = 4'hF;
    for (int i = 0; i < 5; i++) cycle("rr_all");
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) cycle("rr_13");
`endif

    // No requesters: output drains, y and y_ch retain last word.
    mode     = 1'b0;
    in_valid = 4'h0;
    cycle("idle0");
    cycle("idle1");

    // Asynchronous reset in the middle of a cycle while a word is held.
    in_valid = 4'hF;
    sel      = 2'd3;
    cycle("pre_rst");
    y_ready = 1'b0;
    #3;
    chk("pre_rst.held", 64'(y_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst.y",        64'(y),        64'h0);
    chk("arst.y_ch",     64'(y_ch),     64'h0);
    chk("arst.y_valid",  64'(y_valid),  64'h0);
    chk("arst.in_ready", 64'(in_ready), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    y_ready = 1'b1;
    cycle("post_rst");

    // Three-channel instance: out-of-range select grants nothing.
    sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("oor.in_ready3", 64'(in_ready3), 64'h0);
      @(posedge clk);
      #1;
      chk("oor.y_valid3", 64'(y_valid3), 64'h0);
    end
    sel3 = 2'd2;
    #1;
    chk("ch3.in_ready3", 64'(in_ready3), 64'h4);
    @(posedge clk);
    #1;
    chk("ch3.y_valid3", 64'(y_valid3), 64'h1);
    chk("ch3.y3",       64'(y3),       64'hC3);
    chk("ch3.y_ch3",    64'(y_ch3),    64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_nx1_reg.md
MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SELW, default $clog2(CHANNELS), select/channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel data valid.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-009 SHALL have port sel  input  SELW  channel index in fixed-select mode.
REQ-010 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin (only with MUX_RR_EN).
REQ-011 SHALL have port y  output  WIDTH  registered selected data.
REQ-012 SHALL have port y_valid  output  1  y holds an unconsumed word.
REQ-013 SHALL have port y_ch  output  SELW  channel index that produced y.
REQ-014 SHALL have port y_ready  input  1  downstream accept.

Function
REQ-015 SHALL hold one output word; load_en = !y_valid || y_ready.
REQ-016 SHALL assert in_ready[g] = load_en for granted channel g only; all other in_ready bits 0.
REQ-017 SHALL transfer when in_valid[g] && in_ready[g]: next edge y <= in_data[g], y_ch <= g, y_valid <= 1; latency exactly 1 cycle.
REQ-018 SHALL clear y_valid on edge where y_valid && y_ready and no new transfer; y and y_ch retain last value.
REQ-019 SHALL sustain one word per cycle when y_ready held high (simultaneous drain and load, no bubble).
REQ-020 SHALL hold y, y_ch, y_valid stable while y_valid && !y_ready.
REQ-021 Fixed mode: g = sel, combinational; sel >= CHANNELS SHALL grant no channel (in_ready all 0, no transfer).
REQ-022 sel change while y_valid && !y_ready SHALL NOT alter y or y_ch.
REQ-023 in_ready SHALL depend only on sel/mode/pointer, in_valid (RR only) and load_en; never on in_data.

Reset
REQ-024 rst_n low SHALL immediately force y = 0, y_ch = 0, y_valid = 0, RR pointer = 0, independent of clk.
REQ-025 Reset asserted mid-transfer SHALL discard the output word; first load after release occurs no earlier than the first rising edge with rst_n high.
REQ-026 in_ready SHALL be all 0 while rst_n is low.

Configuration
REQ-027 Macro MUX_RR_EN defined: mode = 1 SHALL select round-robin; g = first channel with in_valid high searching ptr, ptr+1, ... wrapping at CHANNELS-1 -> 0; no valid channel -> no grant.
REQ-028 With MUX_RR_EN: after each transfer ptr <= (g+1) mod CHANNELS; ptr unchanged with no transfer; sel ignored in mode 1.
REQ-029 With MUX_RR_EN: mode change takes effect next cycle evaluation; ptr preserved across mode changes.
REQ-030 MUX_RR_EN undefined: mode SHALL be ignored (fixed select always), no pointer register synthesised.

Verification
REQ-031 Reset: rst_n = 0 asynchronously mid-cycle with y_valid = 1 -> y = 0, y_ch = 0, y_valid = 0, in_ready = 0 immediately.
REQ-032 Fixed select, WIDTH = 8, CHANNELS = 4: in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, y_ready = 1, sel = 0,1,2,3 -> y = 11,22,33,44 one cycle after each, y_ch = 0..3.
REQ-033 Backpressure: sel = 2, y_ready = 0 for 3 cycles -> y = 8'h33 held, in_ready = 0000 after first load; y_ready = 1 -> next word loads same edge (no bubble).
REQ-034 Out-of-range: CHANNELS = 3, sel = 3 -> in_ready = 000, y_valid stays 0.
REQ-035 Round-robin (MUX_RR_EN, mode = 1): all four valid, y_ready = 1 -> y_ch sequence 0,1,2,3,0; with only ch1 and ch3 valid -> 1,3,1,3.
REQ-036 Without MUX_RR_EN: mode = 1, sel = 1 -> y_ch = 1 every transfer, identical to mode = 0.
